// File: rtl/shift_reg_sipo_deser.sv
// Serial-in, parallel-out deserializer with a valid/ready word output, one-word
// internal holding slot for downstream stalls, and a sticky overrun flag.
module shift_reg_sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ser_in,
    input  logic                   ser_en,
    input  logic                   frame_sync,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    input  logic                   q_ready,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic [$clog2(WIDTH):0] bit_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  sr_reg;
    logic [WIDTH-1:0]  q_reg;
    logic              q_valid_reg;
    logic              overrun_reg;
    logic [CW-1:0]     bit_cnt_reg;

    logic [WIDTH-1:0]  shift_base;
    logic [WIDTH-1:0]  shift_next;
    logic [CW-1:0]     cnt_eff;
    logic              word_done;
    logic              slot_free;

    // frame_sync restarts the word: the partial contents and count are dropped
    // so the same-cycle bit becomes bit 0.
    assign shift_base = frame_sync ? '0 : sr_reg;
    assign cnt_eff    = frame_sync ? '0 : bit_cnt_reg;
    assign word_done  = ser_en && (cnt_eff == LAST_IDX);
    assign slot_free  = !q_valid_reg || q_ready;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shift_next[gi] = ser_in;
                end else begin : g_mv
                    assign shift_next[gi] = shift_base[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign shift_next[gi] = ser_in;
                end else begin : g_mv
                    assign shift_next[gi] = shift_base[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            sr_reg      <= '0;
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
            overrun_reg <= 1'b0;
            bit_cnt_reg <= '0;
        end else begin
            // Default consume; any word loaded this cycle overrides below.
            if (q_valid_reg && q_ready) begin
                q_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (frame_sync) begin
                        state_reg   <= SHIFT;
                        sr_reg      <= ser_en ? shift_next : '0;
                        bit_cnt_reg <= ser_en ? ONE : '0;
                    end
                end
                SHIFT: begin
                    if (word_done) begin
                        bit_cnt_reg <= '0;
                        if (slot_free) begin
                            q_reg       <= shift_next;
                            q_valid_reg <= 1'b1;
                            sr_reg      <= '0;
                        end else begin
                            // Completed word parks in the shift register.
                            sr_reg    <= shift_next;
                            state_reg <= STALL;
                        end
                    end else if (ser_en) begin
                        sr_reg      <= shift_next;
                        bit_cnt_reg <= cnt_eff + ONE;
                    end else if (frame_sync) begin
                        sr_reg      <= '0;
                        bit_cnt_reg <= '0;
                    end
                end
                STALL: begin
                    // q_valid is always set here, so q_ready alone releases.
                    if (q_ready) begin
                        q_reg       <= sr_reg;
                        q_valid_reg <= 1'b1;
                        sr_reg      <= '0;
                        state_reg   <= SHIFT;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (state_reg == STALL && ser_en) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign q       = q_reg;
    assign q_valid = q_valid_reg;
    assign overrun = overrun_reg;
    assign bit_cnt = bit_cnt_reg;

endmodule
